// File: rtl/hp1349a_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hp1349a_pkg
// Description : Shared definitions for the HP1349A command word path: command
//               and axis codes, word bit positions, encoder FSM states and a
//               helper that assembles a 16-bit command word. Also used by the
//               display-side command decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package hp1349a_pkg;

  localparam logic [1:0] CMD_PLOT  = 2'b00;
  localparam logic [1:0] CMD_GRAPH = 2'b01;

  localparam logic AXIS_X = 1'b0;
  localparam logic AXIS_Y = 1'b1;

  // Word layout: [15]=0, [14:13]=cmd, [12]=axis, [11]=pen, [10:0]=value
  localparam int unsigned BIT_RSVD    = 15;
  localparam int unsigned BIT_CMD_MSB = 14;
  localparam int unsigned BIT_CMD_LSB = 13;
  localparam int unsigned BIT_AXIS    = 12;
  localparam int unsigned BIT_PEN     = 11;
  localparam int unsigned VAL_W       = 11;
  localparam int unsigned WORD_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EVAL = 3'd1,
    ST_INC  = 3'd2,
    ST_PX   = 3'd3,
    ST_PY   = 3'd4,
    ST_GY   = 3'd5
  } state_e;

  function automatic logic [WORD_W-1:0] hp1349a_word(
    input logic [1:0]       cmd,
    input logic             axis,
    input logic             pen,
    input logic [VAL_W-1:0] val
  );
    logic [WORD_W-1:0] w;
    w                          = '0;
    w[BIT_RSVD]                = 1'b0;
    w[BIT_CMD_MSB:BIT_CMD_LSB] = cmd;
    w[BIT_AXIS]                = axis;
    w[BIT_PEN]                 = pen;
    w[VAL_W-1:0]               = val;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hp1349a_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : hp1349a_cmd_encoder
// Description : Writer end of the HP1349A command word FIFO. Turns absolute
//               vector endpoints into plot X/Y pairs, or into single graph Y
//               words when X lands on the decoder's predicted next X.
// Ports       : clk, rst_n (async active-low)
//               vec_valid/vec_ready, vec_x, vec_y, vec_pen - vector request
//               graph_en, graph_inc - graph compression request and step
//               model_clr          - drop next-X / increment model
//               fifo_write_en/fifo_write_data/fifo_full - FIFO write side
// Revision    : 1.0 - initial release
// ============================================================================
module hp1349a_cmd_encoder
  import hp1349a_pkg::*;
#(
  parameter int unsigned GRAPH_ENABLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [VAL_W-1:0]  vec_x,
  input  logic [VAL_W-1:0]  vec_y,
  input  logic              vec_pen,
  input  logic              graph_en,
  input  logic [VAL_W-1:0]  graph_inc,
  input  logic              model_clr,
  output logic              fifo_write_en,
  output logic [WORD_W-1:0] fifo_write_data,
  input  logic              fifo_full
);

  localparam logic GRAPH_OK = (GRAPH_ENABLE != 0);

  state_e           state_q,       state_d;
  logic [VAL_W-1:0] x_q,           x_d;
  logic [VAL_W-1:0] y_q,           y_d;
  logic             pen_q,         pen_d;
  logic             g_q,           g_d;
  logic [VAL_W-1:0] inc_q,         inc_d;
  logic [VAL_W-1:0] inc_sent_q,    inc_sent_d;
  logic             inc_valid_q,   inc_valid_d;
  logic [VAL_W-1:0] model_next_q,  model_next_d;
  logic             model_valid_q, model_valid_d;

  assign vec_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d         = state_q;
    x_d             = x_q;
    y_d             = y_q;
    pen_d           = pen_q;
    g_d             = g_q;
    inc_d           = inc_q;
    inc_sent_d      = inc_sent_q;
    inc_valid_d     = inc_valid_q;
    model_next_d    = model_next_q;
    model_valid_d   = model_valid_q;
    fifo_write_en   = 1'b0;
    fifo_write_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (vec_valid) begin
          x_d     = vec_x;
          y_d     = vec_y;
          pen_d   = vec_pen;
          g_d     = graph_en & GRAPH_OK;
          inc_d   = graph_inc;
          state_d = ST_EVAL;
        end
      end

      ST_EVAL: begin
        // The decoder must hold the increment we intend to rely on before
        // any graph Y word can be emitted.
        if (g_q && (!inc_valid_q || (inc_sent_q != inc_q))) begin
          state_d = ST_INC;
        end else if (g_q && model_valid_q && (x_q == model_next_q)) begin
          state_d = ST_GY;
        end else begin
          state_d = ST_PX;
        end
      end

      ST_INC: begin
        fifo_write_data = hp1349a_word(CMD_GRAPH, AXIS_X, 1'b0, inc_q);
        fifo_write_en   = !fifo_full;
        if (!fifo_full) begin
          inc_sent_d  = inc_q;
          inc_valid_d = 1'b1;
          state_d     = ST_EVAL;
        end
      end

      ST_PX: begin
        fifo_write_data = hp1349a_word(CMD_PLOT, AXIS_X, 1'b0, x_q);
        fifo_write_en   = !fifo_full;
        if (!fifo_full) begin
          // A plot X resets the decoder's next X to x itself, not x+inc.
          model_next_d  = x_q;
          model_valid_d = 1'b1;
          state_d       = ST_PY;
        end
      end

      ST_PY: begin
        fifo_write_data = hp1349a_word(CMD_PLOT, AXIS_Y, pen_q, y_q);
        fifo_write_en   = !fifo_full;
        if (!fifo_full) begin
          state_d = ST_IDLE;
        end
      end

      ST_GY: begin
        fifo_write_data = hp1349a_word(CMD_GRAPH, AXIS_Y, pen_q, y_q);
        fifo_write_en   = !fifo_full;
        if (!fifo_full) begin
          model_next_d = model_next_q + inc_sent_q;  // 11-bit wrap intended
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Resync request overrides any model update made on the same edge.
    if (model_clr) begin
      model_valid_d = 1'b0;
      inc_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      pen_q         <= 1'b0;
      g_q           <= 1'b0;
      inc_q         <= '0;
      inc_sent_q    <= '0;
      inc_valid_q   <= 1'b0;
      model_next_q  <= '0;
      model_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pen_q         <= pen_d;
      g_q           <= g_d;
      inc_q         <= inc_d;
      inc_sent_q    <= inc_sent_d;
      inc_valid_q   <= inc_valid_d;
      model_next_q  <= model_next_d;
      model_valid_q <= model_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hp1349a_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hp1349a_cmd_encoder
// Description : Self-checking bench for hp1349a_cmd_encoder. A table of
//               vectors with hand-computed command words, plus hand-written
//               sequences for reset, latency and FIFO stall corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hp1349a_cmd_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vec_valid = 1'b0;
  logic        vec_ready;
  logic [10:0] vec_x = '0;
  logic [10:0] vec_y = '0;
  logic        vec_pen = 1'b0;
  logic        graph_en = 1'b0;
  logic [10:0] graph_inc = '0;
  logic        model_clr = 1'b0;
  logic        fifo_write_en;
  logic [15:0] fifo_write_data;
  logic        fifo_full = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  hp1349a_cmd_encoder #(.GRAPH_ENABLE(1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .vec_valid       (vec_valid),
    .vec_ready       (vec_ready),
    .vec_x           (vec_x),
    .vec_y           (vec_y),
    .vec_pen         (vec_pen),
    .graph_en        (graph_en),
    .graph_inc       (graph_inc),
    .model_clr       (model_clr),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .fifo_full       (fifo_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;    // reset before this vector
    bit          clr;    // model_clr pulse before this vector
    logic [10:0] x;
    logic [10:0] y;
    logic        pen;
    logic        g;
    logic [10:0] inc;
    int          n;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive_vec(input logic [10:0] x, input logic [10:0] y, input logic pen,
                           input logic g, input logic [10:0] inc);
    vec_x     = x;
    vec_y     = y;
    vec_pen   = pen;
    graph_en  = g;
    graph_inc = inc;
    vec_valid = 1'b1;
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    logic [15:0] exp_w;
    int          k;
    v = vecs[idx];
    if (v.rst) do_reset();
    if (v.clr) begin
      model_clr = 1'b1;
      @(negedge clk);
      model_clr = 1'b0;
    end
    chk($sformatf("v%0d_ready_before", idx), {31'd0, vec_ready}, 32'd1);
    drive_vec(v.x, v.y, v.pen, v.g, v.inc);
    @(negedge clk);
    vec_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      if (fifo_write_en) begin
        exp_w = (k == 0) ? v.w0 : (k == 1) ? v.w1 : v.w2;
        if (k < v.n) chk($sformatf("v%0d_word%0d", idx, k), {16'd0, fifo_write_data}, {16'd0, exp_w});
        else chk($sformatf("v%0d_extra_word", idx), {16'd0, fifo_write_data}, 32'hFFFF_FFFF);
        k++;
      end
      if (vec_ready) break;
      @(negedge clk);
    end
    chk($sformatf("v%0d_word_count", idx), k, v.n);
    chk($sformatf("v%0d_ready_after", idx), {31'd0, vec_ready}, 32'd1);
  endtask

  initial begin
    //            rst clr  x     y    pen g  inc  n   w0        w1        w2
    vecs[0]  = '{1, 0, 11'd100, 11'd200, 1, 1, 11'd4, 3, 16'h2004, 16'h0064, 16'h18C8};
    vecs[1]  = '{0, 0, 11'd100, 11'd300, 1, 1, 11'd4, 1, 16'h392C, 16'h0000, 16'h0000};
    vecs[2]  = '{0, 0, 11'd104, 11'd250, 1, 1, 11'd4, 1, 16'h38FA, 16'h0000, 16'h0000};
    vecs[3]  = '{0, 0, 11'd200, 11'd10,  0, 1, 11'd4, 2, 16'h00C8, 16'h100A, 16'h0000};
    vecs[4]  = '{1, 0, 11'd100, 11'd200, 1, 1, 11'd4, 3, 16'h2004, 16'h0064, 16'h18C8};
    vecs[5]  = '{0, 0, 11'd100, 11'd300, 1, 1, 11'd4, 1, 16'h392C, 16'h0000, 16'h0000};
    vecs[6]  = '{0, 1, 11'd104, 11'd250, 1, 1, 11'd4, 3, 16'h2004, 16'h0068, 16'h18FA};
    vecs[7]  = '{0, 0, 11'd2044, 11'd5,  1, 1, 11'd4, 2, 16'h07FC, 16'h1805, 16'h0000};
    vecs[8]  = '{0, 0, 11'd2044, 11'd7,  1, 1, 11'd4, 1, 16'h3807, 16'h0000, 16'h0000};
    vecs[9]  = '{0, 0, 11'd0,   11'd9,   0, 1, 11'd4, 1, 16'h3009, 16'h0000, 16'h0000};
    vecs[10] = '{0, 0, 11'd500, 11'd1,   1, 0, 11'd4, 2, 16'h01F4, 16'h1801, 16'h0000};
    vecs[11] = '{0, 0, 11'd500, 11'd2,   1, 1, 11'd4, 1, 16'h3802, 16'h0000, 16'h0000};
    vecs[12] = '{0, 0, 11'd504, 11'd3,   0, 1, 11'd8, 2, 16'h2008, 16'h3003, 16'h0000};

    // Reset state
    @(negedge clk);
    chk("rst_en", {31'd0, fifo_write_en}, 32'd0);
    chk("rst_data", {16'd0, fifo_write_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, vec_ready}, 32'd1);

    // Reset asserted while a PX word is stalled by a full FIFO
    fifo_full = 1'b1;
    drive_vec(11'd100, 11'd200, 1'b1, 1'b0, 11'd4);
    @(negedge clk);
    vec_valid = 1'b0;
    @(negedge clk);
    chk("t1_stalled_en", {31'd0, fifo_write_en}, 32'd0);
    chk("t1_stalled_data", {16'd0, fifo_write_data}, 32'h0064);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_en", {31'd0, fifo_write_en}, 32'd0);
    chk("t1_rst_data", {16'd0, fifo_write_data}, 32'd0);
    @(negedge clk);
    fifo_full = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t1_post_ready", {31'd0, vec_ready}, 32'd1);
      chk("t1_post_en", {31'd0, fifo_write_en}, 32'd0);
    end

    // Plot pair latency with graph_en=0
    drive_vec(11'd100, 11'd200, 1'b1, 1'b0, 11'd4);
    @(negedge clk);
    vec_valid = 1'b0;
    chk("t2_eval_en", {31'd0, fifo_write_en}, 32'd0);
    chk("t2_eval_ready", {31'd0, vec_ready}, 32'd0);
    @(negedge clk);
    chk("t2_px_en", {31'd0, fifo_write_en}, 32'd1);
    chk("t2_px_data", {16'd0, fifo_write_data}, 32'h0064);
    @(negedge clk);
    chk("t2_py_en", {31'd0, fifo_write_en}, 32'd1);
    chk("t2_py_data", {16'd0, fifo_write_data}, 32'h18C8);
    @(negedge clk);
    chk("t2_done_ready", {31'd0, vec_ready}, 32'd1);
    chk("t2_done_en", {31'd0, fifo_write_en}, 32'd0);

    // FIFO full for five cycles during PY
    begin
      int writes;
      writes = 0;
      drive_vec(11'd100, 11'd200, 1'b1, 1'b0, 11'd4);
      @(negedge clk);
      vec_valid = 1'b0;
      @(negedge clk);
      chk("t4_px_data", {16'd0, fifo_write_data}, 32'h0064);
      @(negedge clk);
      fifo_full = 1'b1;
      #1;
      for (int c = 0; c < 5; c++) begin
        chk("t4_stall_en", {31'd0, fifo_write_en}, 32'd0);
        chk("t4_stall_data", {16'd0, fifo_write_data}, 32'h18C8);
        @(negedge clk);
      end
      fifo_full = 1'b0;
      #1;
      for (int c = 0; c < 4; c++) begin
        if (fifo_write_en) begin
          writes++;
          chk("t4_release_data", {16'd0, fifo_write_data}, 32'h18C8);
        end
        @(negedge clk);
      end
      chk("t4_write_count", writes, 1);
      chk("t4_ready", {31'd0, vec_ready}, 32'd1);
    end

    // Table: graph sequence, model_clr resync, wrap, graph_en=0, new increment
    for (int i = 0; i < 13; i++) run_vec(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
